// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with per-frame latched baud rate,
// optional parity and one or two stop bits.
// Optional feature: define UART_TX_PARITY_EN to build the PARITY state and
// parity generation; without it parity_mode is ignored and no parity bit is sent.
module uart_tx_cfg #(
    parameter int CLK_HZ    = 50000000,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send_en,
    input  logic [DATA_BITS-1:0] data_byte,
    input  logic [2:0]           baud_set,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 uart_tx,
    output logic                 uart_state,
    output logic                 tx_done
);

    // Bit periods in clock cycles, rounded to nearest.
    localparam int CYC_0 = (CLK_HZ + 4800) / 9600;
    localparam int CYC_1 = (CLK_HZ + 9600) / 19200;
    localparam int CYC_2 = (CLK_HZ + 19200) / 38400;
    localparam int CYC_3 = (CLK_HZ + 28800) / 57600;
    localparam int CYC_4 = (CLK_HZ + 57600) / 115200;
    localparam int CYC_5 = (CLK_HZ + 115200) / 230400;
    localparam int CYC_6 = (CLK_HZ + 230400) / 460800;
    localparam int CYC_7 = (CLK_HZ + 460800) / 921600;

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end

    if (CYC_0 > 65536 || CYC_7 < 1) begin : g_bad_clk_hz
        $error("uart_tx_cfg: CLK_HZ gives a bit period outside the 16-bit counter range");
    end

    // Last count value of a bit period for the selected baud rate.
    function automatic logic [15:0] bit_last(input logic [2:0] sel);
        case (sel)
            3'd0:    bit_last = 16'(CYC_0 - 1);
            3'd1:    bit_last = 16'(CYC_1 - 1);
            3'd2:    bit_last = 16'(CYC_2 - 1);
            3'd3:    bit_last = 16'(CYC_3 - 1);
            3'd4:    bit_last = 16'(CYC_4 - 1);
            3'd5:    bit_last = 16'(CYC_5 - 1);
            3'd6:    bit_last = 16'(CYC_6 - 1);
            default: bit_last = 16'(CYC_7 - 1);
        endcase
    endfunction

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [3:0]           bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [2:0]           baud_l, baud_n;
    logic                 stop2_l, stop2_n;
    logic                 tx_n, busy_n, done_n;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_l, par_en_n;
    logic                 par_bit_l, par_bit_n;
`else
    logic                 unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    // State, counters, latched frame settings and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            baud_l     <= '0;
            stop2_l    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_l   <= 1'b0;
            par_bit_l  <= 1'b0;
`endif
            uart_tx    <= 1'b1;
            uart_state <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            shreg      <= shreg_n;
            baud_l     <= baud_n;
            stop2_l    <= stop2_n;
`ifdef UART_TX_PARITY_EN
            par_en_l   <= par_en_n;
            par_bit_l  <= par_bit_n;
`endif
            uart_tx    <= tx_n;
            uart_state <= busy_n;
            tx_done    <= done_n;
        end
    end

    // Next-state and next-output logic; the line value is computed one edge
    // ahead so uart_tx changes exactly on bit boundaries.
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shreg_n    = shreg;
        baud_n     = baud_l;
        stop2_n    = stop2_l;
`ifdef UART_TX_PARITY_EN
        par_en_n   = par_en_l;
        par_bit_n  = par_bit_l;
`endif
        tx_n       = uart_tx;
        busy_n     = uart_state;
        done_n     = 1'b0;
        bit_end    = (cnt == bit_last(baud_l));
        cnt_n      = bit_end ? '0 : cnt + 16'd1;

        case (state)
            IDLE: begin
                cnt_n  = '0;
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (send_en) begin
                    shreg_n    = data_byte;
                    baud_n     = baud_set;
                    stop2_n    = stop2;
                    bit_idx_n  = '0;
                    stop_idx_n = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                    par_bit_n  = (^data_byte) ^ (parity_mode == 2'b01);
`endif
                    state_n    = START;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_l) begin
                            state_n = PARITY;
                            tx_n    = par_bit_l;
                        end else
`endif
                        begin
                            state_n    = STOP;
                            stop_idx_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_idx_n = 1'b0;
                    tx_n       = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    if (stop2_l && !stop_idx) begin
                        stop_idx_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a frame-level reference model (bit list
// plus elapsed-cycle counter) checked every cycle, plus literal frame checks.
module tb_uart_tx_cfg;

    localparam int CLK_HZ    = 50000000;
    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_ON = 1;
`else
    localparam int PAR_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_en = 1'b0;
    logic [7:0] data_byte = 8'h00;
    logic [2:0] baud_set = 3'd4;
    logic [1:0] parity_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic       uart_tx, uart_state, tx_done;

    int n_checks = 0;
    int n_fail = 0;

    uart_tx_cfg #(.CLK_HZ(CLK_HZ), .DATA_BITS(DATA_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .send_en(send_en), .data_byte(data_byte),
        .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
        .uart_tx(uart_tx), .uart_state(uart_state), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int bauds [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_k = 0;
    int m_len = 1;
    int m_b = 1;
    int m_n;
    int m_ones;
    bit m_frame [16];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_k++;
                if (m_k == m_len * m_b) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (send_en) begin
                m_b = (CLK_HZ + bauds[baud_set] / 2) / bauds[baud_set];
                m_frame[0] = 1'b0;
                m_ones = 0;
                for (int i = 0; i < DATA_BITS; i++) begin
                    m_frame[1 + i] = data_byte[i];
                    m_ones += int'(data_byte[i]);
                end
                m_n = 1 + DATA_BITS;
                if (PAR_ON == 1 && (parity_mode == 2'd1 || parity_mode == 2'd2)) begin
                    m_frame[m_n] = (parity_mode == 2'd1) ? ((m_ones % 2) == 0) : ((m_ones % 2) == 1);
                    m_n++;
                end
                m_frame[m_n] = 1'b1;
                m_n++;
                if (stop2) begin
                    m_frame[m_n] = 1'b1;
                    m_n++;
                end
                m_len  = m_n;
                m_k    = 0;
                m_busy = 1'b1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    int exp_tx;
    initial forever begin
        @(negedge clk);
        exp_tx = m_busy ? int'(m_frame[m_k / m_b]) : 1;
        check("cyc_uart_tx", int'(uart_tx), exp_tx);
        check("cyc_uart_state", int'(uart_state), int'(m_busy));
        check("cyc_tx_done", int'(tx_done), int'(m_done));
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] d, input logic [2:0] b, input logic [1:0] pm, input logic s2);
        data_byte   = d;
        baud_set    = b;
        parity_mode = pm;
        stop2       = s2;
        send_en     = 1'b1;
        @(negedge clk);
        send_en     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int j);
        j = 0;
        while (!tx_done && j < limit) begin
            @(negedge clk);
            j++;
        end
        if (!tx_done) check("tx_done_timeout", 0, 1);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int jj, lo;
    logic [9:0] seq_8n1;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_uart_tx", int'(uart_tx), 1);
        check("rst_uart_state", int'(uart_state), 0);
        check("rst_tx_done", int'(tx_done), 0);
        skip(2);
        #3 rst_n = 1'b1;
        skip(3);
        check("idle_after_reset", int'(uart_state), 0);

        // 8N1, 0xA5 at 115200: mid-bit samples and frame length
        seq_8n1 = 10'b11_0100_1010; // index 0 = start bit
        send(8'hA5, 3'd4, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            skip((i == 0) ? 217 : 434);
            check($sformatf("a5_bit%0d", i), int'(uart_tx), int'(seq_8n1[i]));
        end
        wait_done(1000, jj);
        check("a5_len", 4123 + jj, 4340);

        // Even parity, two stops, 0x07; mid-frame send_en and input changes ignored
        skip(2);
        send(8'h07, 3'd4, 2'b10, 1'b1);
        skip(999);
        send_en     = 1'b1;
        data_byte   = 8'hFF;
        baud_set    = 3'd7;
        parity_mode = 2'b01;
        stop2       = 1'b0;
        @(negedge clk);
        send_en = 1'b0;
        if (PAR_ON == 1) begin
            skip(9 * 434 + 217 - 1000);
            check("e2_parity_bit", int'(uart_tx), 1);
            wait_done(2000, jj);
            check("e2_len", 9 * 434 + 217 + jj, 12 * 434);
        end else begin
            wait_done(6000, jj);
            check("e2_len", 1000 + jj, 11 * 434);
        end
        skip(3);
        check("busy_send_ignored", int'(uart_state), 0);

        // Odd parity request with 0x00
        send(8'h00, 3'd4, 2'b01, 1'b0);
        wait_done(6000, jj);
        check("o1_len", jj, (10 + PAR_ON) * 434);

        // Back-to-back at 921600 with send_en held high
        skip(2);
        data_byte   = 8'h3C;
        baud_set    = 3'd7;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        send_en     = 1'b1;
        @(negedge clk);
        wait_done(2000, jj);
        check("b2b_len", jj, 540);
        @(negedge clk);
        check("b2b_start_tx", int'(uart_tx), 0);
        check("b2b_start_busy", int'(uart_state), 1);
        skip(3000);
        send_en = 1'b0;
        wait_done(2000, jj);
        skip(2);

        // 9600 baud start bit, mid-frame baud change, then reset during data bit
        send(8'h01, 3'd0, 2'b00, 1'b0);
        lo = 0;
        while (uart_tx == 1'b0 && lo < 6000) begin
            @(negedge clk);
            lo++;
        end
        check("baud0_bit_cycles", lo, 5208);
        baud_set = 3'd7;
        skip(100);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_uart_tx", int'(uart_tx), 1);
        check("midrst_uart_state", int'(uart_state), 0);
        check("midrst_tx_done", int'(tx_done), 0);
        skip(3);
        #3 rst_n = 1'b1;
        skip(5);
        check("post_rst_idle", int'(uart_state), 0);

        // 921600 baud start bit and frame length after reset
        send(8'h01, 3'd7, 2'b00, 1'b0);
        lo = 0;
        while (uart_tx == 1'b0 && lo < 1000) begin
            @(negedge clk);
            lo++;
        end
        check("baud7_bit_cycles", lo, 54);
        wait_done(1000, jj);
        check("baud7_len", lo + jj, 540);

        // Randomized traffic at the faster rates; inputs churn every cycle
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            send_en = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                data_byte   = 8'($urandom);
                baud_set    = 3'(4 + $urandom_range(0, 3));
                parity_mode = 2'($urandom_range(0, 3));
                stop2       = 1'($urandom_range(0, 1));
            end
        end
        send_en = 1'b0;
        skip(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
